// File: rtl/expr_conv_scheduler_if.sv
// Requester/converter signal bundle for expr_conv_scheduler.
// slave = scheduler side, master = requesters plus converter side.
interface expr_conv_scheduler_if #(
    parameter int W = 8
);
    logic [1:0]   Req;
    logic [W-1:0] SymIn0;
    logic [W-1:0] SymIn1;
    logic [1:0]   SymValid;
    logic [1:0]   SymReady;
    logic [1:0]   Gnt;
    logic [1:0]   Done;
    logic [1:0]   Trunc;
    logic         Busy;
    logic         ConvST;
    logic [W-1:0] ConvSym;
    logic         ConvReady;

    modport slave (
        input  Req, SymIn0, SymIn1, SymValid, ConvReady,
        output SymReady, Gnt, Done, Trunc, Busy, ConvST, ConvSym
    );

    modport master (
        output Req, SymIn0, SymIn1, SymValid, ConvReady,
        input  SymReady, Gnt, Done, Trunc, Busy, ConvST, ConvSym
    );
endinterface

// File: rtl/expr_conv_scheduler.sv
// Round-robin scheduler sharing one infix-to-postfix converter between two requesters.
// Optional WAIT watchdog with Err output is enabled by defining SCHED_TIMEOUT_EN.
module expr_conv_scheduler #(
    parameter int W       = 8,
    parameter int N       = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    expr_conv_scheduler_if.slave bus
`ifdef SCHED_TIMEOUT_EN
    ,
    output logic                 Err
`endif
);
    localparam int           CW  = $clog2(N);
    localparam logic [W-1:0] DOT = W'(8'h2E);

    typedef enum logic [2:0] {IDLE, ARB, START, STREAM, INJECT, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic          ptr;
    logic [CW-1:0] count;
    logic          guard;
    logic          sel;
    logic          arb_pick;
    logic          req_g;
    logic          vld_g;
    logic [W-1:0]  sym_g;
    logic          ready_exit;
    logic          timeout_hit;

    assign sel          = bus.Gnt[1];
    assign req_g        = bus.Req[sel];
    assign vld_g        = bus.SymValid[sel];
    assign sym_g        = sel ? bus.SymIn1 : bus.SymIn0;
    assign arb_pick     = bus.Req[ptr] ? ptr : ~ptr;
    assign ready_exit   = !guard && bus.ConvReady;
    assign bus.SymReady = (state == STREAM) ? bus.Gnt : 2'b00;

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)           wait_cnt <= '0;
        else if (state != WAIT) wait_cnt <= '0;
        else                    wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if ((|bus.Req) && bus.ConvReady) state_n = ARB;
            ARB:     state_n = START;
            START:   state_n = STREAM;
            STREAM: begin
                if (!req_g) begin
                    state_n = WAIT;
                end else if (vld_g) begin
                    if (sym_g == DOT)                state_n = WAIT;
                    else if (count == CW'(N - 2))    state_n = INJECT;
                end
            end
            INJECT:  state_n = WAIT;
            WAIT:    if (ready_exit || timeout_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Gnt     <= 2'b00;
            bus.Done    <= 2'b00;
            bus.Trunc   <= 2'b00;
            bus.Busy    <= 1'b0;
            bus.ConvST  <= 1'b0;
            bus.ConvSym <= '0;
            ptr         <= 1'b0;
            count       <= '0;
            guard       <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            Err         <= 1'b0;
`endif
        end else begin
            bus.ConvST  <= (state == START);
            bus.Busy    <= (state_n != IDLE);
            bus.Done    <= 2'b00;
            bus.ConvSym <= '0;
            guard       <= (state_n == WAIT) && (state != WAIT);
`ifdef SCHED_TIMEOUT_EN
            Err         <= (state == WAIT) && (state_n == DONE) && !ready_exit;
`endif
            case (state)
                ARB: begin
                    bus.Gnt             <= arb_pick ? 2'b10 : 2'b01;
                    bus.Trunc[arb_pick] <= 1'b0;
                end
                STREAM: begin
                    // A dropped request ends the job with an injected terminator
                    if (!req_g) begin
                        bus.ConvSym    <= DOT;
                        bus.Trunc[sel] <= 1'b1;
                    end else if (vld_g) begin
                        bus.ConvSym <= sym_g;
                        count       <= count + 1'b1;
                    end
                end
                INJECT: begin
                    bus.ConvSym    <= DOT;
                    bus.Trunc[sel] <= 1'b1;
                end
                DONE: begin
                    bus.Gnt <= 2'b00;
                    count   <= '0;
                    ptr     <= ~sel;
                end
                default: ;
            endcase
            if ((state == WAIT) && (state_n == DONE)) bus.Done <= bus.Gnt;
        end
    end
endmodule

// File: doc/expr_conv_scheduler.md
Name: expr_conv_scheduler

Overview:
- Shares one infix-to-postfix converter between two requesters.
- Picks a requester round-robin, then pulses the converter's start input.
- Streams that requester's symbols into the converter one per cycle, including the terminating ".".
- Waits for the converter's Ready, then signals completion. Sits between the expression sources and the converter instance.

Parameters:
- W, 8, symbol width in bits (matches converter W).
- N, 32, maximum symbols per expression including "." (matches converter stack depth).
- TIMEOUT, 256, watchdog limit in cycles for WAIT state (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  2  per-requester job request; level, held until matching Done.
- SymIn0  in  W  requester 0 symbol.
- SymIn1  in  W  requester 1 symbol.
- SymValid  in  2  per-requester symbol valid.
- SymReady  out  2  per-requester symbol accept; only the granted bit may be 1.
- Gnt  out  2  one-hot grant, held from arbitration to Done.
- Done  out  2  one-cycle completion pulse for the granted requester.
- Trunc  out  2  set with Done if the scheduler injected "."; cleared at next grant of that requester.
- Busy  out  1  high in every state except IDLE.
- ConvST  out  1  converter start; one-cycle pulse.
- ConvSym  out  W  converter InputSymbol; 0 means no symbol.
- ConvReady  in  1  converter Ready.

Behaviour:
- Reset (async, Reset_n=0): state IDLE.
  - Gnt, Done, Trunc, SymReady = 0; ConvST = 0; ConvSym = 0; Busy = 0.
  - Round-robin pointer favours requester 0; symbol count = 0.
- Reset mid-job: the job is dropped silently with no Done. The converter is reset by its own reset; the scheduler does not sequence it.
- All outputs are registered except SymReady, which is decoded from state and Gnt.
- IDLE -> ARB when any Req=1 and ConvReady=1.
- ARB: grant the requester favoured by the pointer if its Req=1, else the other. Latch Gnt, clear that requester's Trunc. -> START.
- START: ConvST=1 for exactly one cycle. -> STREAM.
- STREAM: SymReady[g]=1.
  - On SymValid[g]=1: ConvSym <= SymIn[g] next cycle; count increments. Otherwise ConvSym <= 0.
  - Accepted symbol == "." -> WAIT.
  - Count reaches N-1 with no "." seen: the next cycle SymReady=0, ConvSym <= ".", Trunc[g] <= 1, -> WAIT.
  - Req[g] drops during STREAM: same injection of ".", Trunc[g] <= 1, -> WAIT.
  - SymValid from the non-granted requester is ignored.
- WAIT: ConvSym <= 0. The first cycle is a guard cycle that ignores ConvReady. Afterwards, ConvReady=1 -> DONE.
- DONE: Done[g]=1 for one cycle. Pointer <= other requester. Gnt <= 0; count <= 0. -> IDLE.
- Latency: ConvST is asserted 2 cycles after Req is first seen in IDLE. The first symbol reaches ConvSym 1 cycle after its handshake.
- Simultaneous Req: the pointer decides. Back-to-back jobs alternate when both requesters stay requesting.
- Req asserted by the non-granted requester while busy: held pending, arbitrated at the next IDLE.
- Symbol value 0 from a requester: accepted and counted, forwarded as 0 (converter ignores it).

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined:
  - Adds output Err (1 bit, reset 0) and a WAIT cycle counter.
  - If ConvReady stays 0 for TIMEOUT cycles in WAIT, go to DONE, pulse Done[g], and set Err=1 for that same cycle.
  - Counter clears on entry to WAIT.
- Not defined: no Err port, no counter; WAIT waits indefinitely.

Test Plan:
- Req=01, requester 0 streams "2+3*5." at one symbol per cycle, converter model Ready -> ConvST pulses once 2 cycles after Req; ConvSym shows "2","+","3","*","5","." on consecutive cycles; Done=01 one cycle after Ready rises; Trunc=00.
- Req=11 together after reset -> requester 0 served first; requester 1 is granted on the cycle after returning to IDLE; a third job with Req=11 is granted to requester 0 again.
- N=32, requester streams 40 non-"." symbols -> 31 accepted, SymReady drops, ConvSym="." injected, Done with Trunc[g]=1.
- Req[0] drops after 3 symbols -> "." injected on the next cycle, Trunc[0]=1, Done[0] pulses after Ready.
- Reset_n pulled low mid-STREAM -> all outputs 0 immediately, no Done; next Req restarts cleanly at ARB.
- With SCHED_TIMEOUT_EN and TIMEOUT=16, ConvReady held 0 -> Done and Err pulse together 16 cycles after entering WAIT.
